// File: rtl/alu_ctrl_fsm.sv
module alu_ctrl_fsm #(
  parameter int unsigned REG_AW  = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned HAS_IMM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              execute,
  input  logic [2:0]        opcode,
  input  logic [REG_AW-1:0] rx,
  input  logic [REG_AW-1:0] ry,
  output logic              ext_sel,
  output logic              g_out,
  output logic              a_in,
  output logic              g_in,
  output logic              add_sub,
  output logic              imm_out,
  output logic              dp_in,
  output logic              rd_en,
  output logic [REG_AW-1:0] rd_addr,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [3:0]        cur_state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    READ_Y  = 4'd2,
    READ_X  = 4'd3,
    ADD     = 4'd4,
    SUB     = 4'd5,
    MV      = 4'd6,
    WRITE_X = 4'd7,
    DONE    = 4'd8,
    SUBI    = 4'd9,
    ADDI    = 4'd10,
    DISP    = 4'd11,
    ERR     = 4'd12
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rx_q;
  logic [REG_AW-1:0] ry_q;

  // Instruction latch, sequencing and completion counter share one block;
  // the counter steps on the transitions that enter DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (execute) begin
            op_q <= opcode;
            rx_q <= rx;
            ry_q <= ry;
            case (opcode)
              3'b000:         state <= LOAD;
              3'b001, 3'b011: state <= READ_Y;
              3'b010:         state <= READ_X;
              3'b100:         state <= DISP;
              3'b110, 3'b111: state <= (HAS_IMM != 0) ? READ_X : ERR;
              default:        state <= ERR;
            endcase
          end
        end
        LOAD, WRITE_X, DISP: begin
          state     <= DONE;
          instr_cnt <= instr_cnt + 1'b1;
        end
        READ_Y:  state <= (op_q == 3'b011) ? ADD : MV;
        READ_X: begin
          case (op_q)
            3'b110:  state <= SUBI;
            3'b111:  state <= ADDI;
            default: state <= SUB;
          endcase
        end
        ADD, SUB, MV, ADDI, SUBI: state <= WRITE_X;
        DONE, ERR: begin
          if (!execute) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ext_sel = 1'b0;
    g_out   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    add_sub = 1'b0;
    imm_out = 1'b0;
    dp_in   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    case (state)
      LOAD: begin
        ext_sel = 1'b1;
        wr_en   = 1'b1;
        wr_addr = rx_q;
      end
      READ_Y: begin
        a_in    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ry_q;
      end
      READ_X: begin
        a_in    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = rx_q;
      end
      ADD: begin
        g_in    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = rx_q;
      end
      SUB: begin
        g_in    = 1'b1;
        add_sub = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ry_q;
      end
      MV: begin
        g_in = 1'b1;
      end
      ADDI: begin
        g_in    = 1'b1;
        imm_out = 1'b1;
      end
      SUBI: begin
        g_in    = 1'b1;
        imm_out = 1'b1;
        add_sub = 1'b1;
      end
      WRITE_X: begin
        g_out   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = rx_q;
      end
      DISP: begin
        dp_in   = 1'b1;
        rd_en   = 1'b1;
        rd_addr = rx_q;
      end
      default: ;
    endcase
  end

  assign busy      = !(state inside {IDLE, DONE, ERR});
  assign done      = (state == DONE);
  assign illegal   = (state == ERR);
  assign cur_state = state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

  // strobe vector: {ext_sel,g_out,a_in,g_in,add_sub,imm_out,dp_in,rd_en,wr_en,busy,done,illegal}
  localparam logic [11:0] S_IDLE = 12'b0000_0000_0000;
  localparam logic [11:0] S_LOAD = 12'b1000_0000_1100;
  localparam logic [11:0] S_RD   = 12'b0010_0001_0100;
  localparam logic [11:0] S_ADD  = 12'b0001_0001_0100;
  localparam logic [11:0] S_SUB  = 12'b0001_1001_0100;
  localparam logic [11:0] S_MV   = 12'b0001_0000_0100;
  localparam logic [11:0] S_ADDI = 12'b0001_0100_0100;
  localparam logic [11:0] S_SUBI = 12'b0001_1100_0100;
  localparam logic [11:0] S_WRX  = 12'b0100_0000_1100;
  localparam logic [11:0] S_DISP = 12'b0000_0011_0100;
  localparam logic [11:0] S_DONE = 12'b0000_0000_0010;
  localparam logic [11:0] S_ERR  = 12'b0000_0000_0001;

  typedef struct {
    int          d;
    logic [3:0]  st;
    logic [11:0] sb;
    logic [1:0]  rda;
    logic [1:0]  wra;
    logic [7:0]  cnt;
    string       nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       execute = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] rx = '0;
  logic [1:0] ry = '0;

  logic [11:0] sb0, sb1, sb2;
  logic [1:0]  rd0, rd1, rd2, wr0, wr1, wr2;
  logic [3:0]  st0, st1, st2;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .execute(execute), .opcode(opcode), .rx(rx), .ry(ry),
    .ext_sel(sb0[11]), .g_out(sb0[10]), .a_in(sb0[9]), .g_in(sb0[8]), .add_sub(sb0[7]),
    .imm_out(sb0[6]), .dp_in(sb0[5]), .rd_en(sb0[4]), .rd_addr(rd0), .wr_en(sb0[3]),
    .wr_addr(wr0), .busy(sb0[2]), .done(sb0[1]), .illegal(sb0[0]),
    .instr_cnt(cnt0), .cur_state(st0)
  );

  alu_ctrl_fsm #(.HAS_IMM(0)) u_noimm (
    .clk(clk), .rst_n(rst_n), .execute(execute), .opcode(opcode), .rx(rx), .ry(ry),
    .ext_sel(sb1[11]), .g_out(sb1[10]), .a_in(sb1[9]), .g_in(sb1[8]), .add_sub(sb1[7]),
    .imm_out(sb1[6]), .dp_in(sb1[5]), .rd_en(sb1[4]), .rd_addr(rd1), .wr_en(sb1[3]),
    .wr_addr(wr1), .busy(sb1[2]), .done(sb1[1]), .illegal(sb1[0]),
    .instr_cnt(cnt1), .cur_state(st1)
  );

  alu_ctrl_fsm #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .execute(execute), .opcode(opcode), .rx(rx), .ry(ry),
    .ext_sel(sb2[11]), .g_out(sb2[10]), .a_in(sb2[9]), .g_in(sb2[8]), .add_sub(sb2[7]),
    .imm_out(sb2[6]), .dp_in(sb2[5]), .rd_en(sb2[4]), .rd_addr(rd2), .wr_en(sb2[3]),
    .wr_addr(wr2), .busy(sb2[2]), .done(sb2[1]), .illegal(sb2[0]),
    .instr_cnt(cnt2), .cur_state(st2)
  );

  function automatic logic [27:0] get_snap(input int d);
    case (d)
      0:       return {st0, sb0, rd0, wr0, cnt0};
      1:       return {st1, sb1, rd1, wr1, cnt1};
      default: return {st2, sb2, rd2, wr2, 6'b0, cnt2};
    endcase
  endfunction

  function automatic void check(input string nm, input logic [27:0] got, input logic [27:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got st=%0d sb=%b rd=%0d wr=%0d cnt=%0d exp st=%0d sb=%b rd=%0d wr=%0d cnt=%0d",
               nm, got[27:24], got[23:12], got[11:10], got[9:8], got[7:0],
               want[27:24], want[23:12], want[11:10], want[9:8], want[7:0]);
    end
  endfunction

  function automatic void push(input int d, input logic [3:0] st, input logic [11:0] sb,
                               input logic [1:0] rda, input logic [1:0] wra,
                               input logic [7:0] cnt, input string nm);
    exp_t e;
    e.d = d; e.st = st; e.sb = sb; e.rda = rda; e.wra = wra; e.cnt = cnt; e.nm = nm;
    exp_q.push_back(e);
  endfunction

  // Called at a negedge; execute stays high for n edges, then one edge back to IDLE.
  task automatic go(input logic [2:0] op, input logic [1:0] x, input logic [1:0] y, input int n);
    opcode  = op;
    rx      = x;
    ry      = y;
    execute = 1'b1;
    repeat (n) @(negedge clk);
    execute = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // monitor: one expected entry per clock edge while the queue holds any
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.nm, get_snap(e.d), {e.st, e.sb, e.rda, e.wra, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] x;
    logic [7:0] prev_c, post_c;
    #1;
    check("reset0", get_snap(0), '0);
    check("reset1", get_snap(1), '0);
    check("reset2", get_snap(2), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted while in ADD
    push(0, 4'd2, S_RD,  2'd1, 2'd0, 8'd0, "rst_ready");
    push(0, 4'd4, S_ADD, 2'd2, 2'd0, 8'd0, "rst_add");
    opcode = 3'b011; rx = 2'd2; ry = 2'd1; execute = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", get_snap(0), '0);
    execute = 1'b0;
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd0, "rst_hold_a");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd0, "rst_hold_b");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd0, "rst_after_a");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd0, "rst_after_b");
    repeat (2) @(negedge clk);

    // addi traps when immediates are disabled
    for (int unsigned i = 0; i < 4; i++)
      push(1, 4'd12, S_ERR, 2'd0, 2'd0, 8'd0, "noimm_err");
    push(1, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd0, "noimm_idle");
    go(3'b111, 2'd1, 2'd2, 4);
    reset_pulse();

    // add, execute held one extra edge in DONE
    push(0, 4'd2, S_RD,   2'd1, 2'd0, 8'd0, "add_ready");
    push(0, 4'd4, S_ADD,  2'd2, 2'd0, 8'd0, "add_add");
    push(0, 4'd7, S_WRX,  2'd0, 2'd2, 8'd0, "add_wr");
    push(0, 4'd8, S_DONE, 2'd0, 2'd0, 8'd1, "add_done");
    push(0, 4'd8, S_DONE, 2'd0, 2'd0, 8'd1, "add_hold");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd1, "add_idle");
    go(3'b011, 2'd2, 2'd1, 5);

    // sub with opcode/rx changed after the start edge
    push(0, 4'd3, S_RD,   2'd3, 2'd0, 8'd1, "sub_readx");
    push(0, 4'd5, S_SUB,  2'd0, 2'd0, 8'd1, "sub_sub");
    push(0, 4'd7, S_WRX,  2'd0, 2'd3, 8'd1, "sub_wr");
    push(0, 4'd8, S_DONE, 2'd0, 2'd0, 8'd2, "sub_done");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd2, "sub_idle");
    opcode = 3'b010; rx = 2'd3; ry = 2'd0; execute = 1'b1;
    @(negedge clk);
    opcode = 3'b000; rx = 2'd1;
    repeat (3) @(negedge clk);
    execute = 1'b0;
    @(negedge clk);

    // reserved opcode
    for (int unsigned i = 0; i < 3; i++)
      push(0, 4'd12, S_ERR, 2'd0, 2'd0, 8'd2, "ill_err");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd2, "ill_idle");
    go(3'b101, 2'd1, 2'd2, 3);

    // subi
    push(0, 4'd3, S_RD,   2'd1, 2'd0, 8'd2, "subi_readx");
    push(0, 4'd9, S_SUBI, 2'd0, 2'd0, 8'd2, "subi_op");
    push(0, 4'd7, S_WRX,  2'd0, 2'd1, 8'd2, "subi_wr");
    push(0, 4'd8, S_DONE, 2'd0, 2'd0, 8'd3, "subi_done");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd3, "subi_idle");
    go(3'b110, 2'd1, 2'd3, 4);

    // disp
    push(0, 4'd11, S_DISP, 2'd3, 2'd0, 8'd3, "disp_op");
    push(0, 4'd8,  S_DONE, 2'd0, 2'd0, 8'd4, "disp_done");
    push(0, 4'd0,  S_IDLE, 2'd0, 2'd0, 8'd4, "disp_idle");
    go(3'b100, 2'd3, 2'd0, 2);

    // move
    push(0, 4'd2, S_RD,   2'd3, 2'd0, 8'd4, "mv_ready");
    push(0, 4'd6, S_MV,   2'd0, 2'd0, 8'd4, "mv_op");
    push(0, 4'd7, S_WRX,  2'd0, 2'd0, 8'd4, "mv_wr");
    push(0, 4'd8, S_DONE, 2'd0, 2'd0, 8'd5, "mv_done");
    push(0, 4'd0, S_IDLE, 2'd0, 2'd0, 8'd5, "mv_idle");
    go(3'b001, 2'd0, 2'd3, 4);

    // addi with rx == ry
    push(0, 4'd3,  S_RD,   2'd2, 2'd0, 8'd5, "addi_readx");
    push(0, 4'd10, S_ADDI, 2'd0, 2'd0, 8'd5, "addi_op");
    push(0, 4'd7,  S_WRX,  2'd0, 2'd2, 8'd5, "addi_wr");
    push(0, 4'd8,  S_DONE, 2'd0, 2'd0, 8'd6, "addi_done");
    push(0, 4'd0,  S_IDLE, 2'd0, 2'd0, 8'd6, "addi_idle");
    go(3'b111, 2'd2, 2'd2, 4);

    // counter wrap on the 2-bit counter instance
    reset_pulse();
    for (int unsigned i = 0; i < 5; i++) begin
      x      = 2'(i);
      prev_c = 8'(i % 4);
      post_c = 8'((i + 1) % 4);
      push(2, 4'd1, S_LOAD, 2'd0, x,    prev_c, "wrap_load");
      push(2, 4'd8, S_DONE, 2'd0, 2'd0, post_c, "wrap_done");
      push(2, 4'd0, S_IDLE, 2'd0, 2'd0, post_c, "wrap_idle");
      go(3'b000, x, 2'd0, 2);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries left exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
